// File: rtl/bp_be_issue_queue_roll_if.sv
// Handshake bundle between the FE queue producer, the issue queue and the BE
// scheduler. The master modport is the side that drives enqueues, dequeue
// acknowledges and commit/rollback/flush controls; the slave modport is the
// issue queue itself.
interface bp_be_issue_queue_roll_if
  #(parameter int entry_width_p = 128
   ,parameter int els_p         = 16
   );

   localparam int ptr_width_lp = $clog2(els_p) + 1;

   logic [entry_width_p-1:0] enq_data_i;
   logic                     enq_v_i;
   logic                     enq_ready_o;
   logic [entry_width_p-1:0] deq_data_o;
   logic                     deq_v_o;
   logic                     deq_yumi_i;
   logic                     cmt_i;
   logic                     roll_i;
   logic                     clr_i;
   logic [ptr_width_lp-1:0]  count_o;

   modport master
     (output enq_data_i
     ,output enq_v_i
     ,input  enq_ready_o
     ,input  deq_data_o
     ,input  deq_v_o
     ,output deq_yumi_i
     ,output cmt_i
     ,output roll_i
     ,output clr_i
     ,input  count_o
     );

   modport slave
     (input  enq_data_i
     ,input  enq_v_i
     ,output enq_ready_o
     ,output deq_data_o
     ,output deq_v_o
     ,input  deq_yumi_i
     ,input  cmt_i
     ,input  roll_i
     ,input  clr_i
     ,output count_o
     );

endinterface

// File: rtl/bp_be_issue_queue_roll.sv
// FE->BE issue queue with speculative read, commit and rollback pointers.
//
// Three pointers walk a flop array:
//   wptr - next slot to write
//   rptr - next entry to hand to the scheduler (speculative)
//   cptr - oldest entry not yet committed
// Each pointer carries one extra wrap bit so full (wptr-cptr == els_p) and
// empty (equal pointers) are distinguishable. Space is freed only by commit;
// a rollback rewinds rptr to cptr so uncommitted entries replay.
//
// Optional feature, macro BP_BE_ISSUE_QUEUE_BYPASS_EN:
//   When defined, an enqueue into a queue with nothing left to issue is
//   forwarded combinationally to deq_data_o/deq_v_o in the same cycle (the
//   entry is still written, so a later rollback can replay it). Bypass is
//   suppressed in flush and rollback cycles.
//   When undefined, there is no combinational path from enq_* to deq_*.
module bp_be_issue_queue_roll
  #(parameter int entry_width_p = 128
   ,parameter int els_p         = 16
   )
   (input logic                    clk_i
   ,input logic                    reset_n_i
   ,bp_be_issue_queue_roll_if.slave q_if
   );

   localparam int idx_width_lp = $clog2(els_p);
   localparam int ptr_width_lp = idx_width_lp + 1;

   typedef logic [ptr_width_lp-1:0] ptr_t;

   ptr_t wptr_r, rptr_r, cptr_r;
   ptr_t wptr_n, rptr_n, cptr_n;
   ptr_t cptr_cmt;
   ptr_t count;

   logic [entry_width_p-1:0] mem_r [els_p];

   logic                     ready_en_r;
   logic                     full;
   logic                     issue_empty;
   logic                     enq_ready;
   logic                     enq_fire;
   logic                     deq_v;
   logic [entry_width_p-1:0] deq_data;
   logic                     yumi_ok;
   logic                     cmt_ok;

   // Occupancy counts issued-but-uncommitted entries as well as unissued ones,
   // so the modular difference against the commit pointer is the true fill.
   assign count       = wptr_r - cptr_r;
   assign full        = (count == ptr_t'(els_p));
   assign issue_empty = (rptr_r == wptr_r);

   // ready_en_r holds enq_ready low while reset is asserted and releases it
   // on the first clock after reset deasserts. A flush cycle refuses new
   // entries, and a full queue refuses even if a commit frees a slot this
   // cycle (the freed slot becomes usable next cycle).
   assign enq_ready = ready_en_r & ~full & ~q_if.clr_i;
   assign enq_fire  = q_if.enq_v_i & enq_ready;

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
   logic byp_v;

   // Forward the incoming packet when nothing older is waiting to issue.
   // enq_fire is already low during a flush; rollback cycles must not
   // forward because the read pointer is being rewritten.
   assign byp_v    = issue_empty & enq_fire & ~q_if.roll_i;
   assign deq_v    = ~issue_empty | byp_v;
   assign deq_data = byp_v ? q_if.enq_data_i : mem_r[rptr_r[idx_width_lp-1:0]];
`else
   assign deq_v    = ~issue_empty;
   assign deq_data = mem_r[rptr_r[idx_width_lp-1:0]];
`endif

   // Illegal acknowledges are filtered here so the pointers simply hold.
   assign yumi_ok = q_if.deq_yumi_i & deq_v;
   assign cmt_ok  = q_if.cmt_i & (cptr_r != rptr_r);

   assign cptr_cmt = cptr_r + ptr_t'(cmt_ok);

   // Next-pointer selection: flush beats rollback beats normal operation.
   always_comb begin
      wptr_n = wptr_r;
      rptr_n = rptr_r;
      cptr_n = cptr_r;
      if (q_if.clr_i) begin
         // Drop everything: both trailing pointers jump to the write pointer.
         rptr_n = wptr_r;
         cptr_n = wptr_r;
      end else if (q_if.roll_i) begin
         // A commit in the rollback cycle retires first, then the read
         // pointer rewinds onto the updated commit pointer. Enqueue proceeds.
         wptr_n = wptr_r + ptr_t'(enq_fire);
         cptr_n = cptr_cmt;
         rptr_n = cptr_cmt;
      end else begin
         wptr_n = wptr_r + ptr_t'(enq_fire);
         rptr_n = rptr_r + ptr_t'(yumi_ok);
         cptr_n = cptr_cmt;
      end
   end

   // Pointer and ready-enable state, cleared asynchronously.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r     <= '0;
         rptr_r     <= '0;
         cptr_r     <= '0;
         ready_en_r <= 1'b0;
      end else begin
         wptr_r     <= wptr_n;
         rptr_r     <= rptr_n;
         cptr_r     <= cptr_n;
         ready_en_r <= 1'b1;
      end
   end

   // Packet storage; contents are intentionally left unreset.
   always_ff @(posedge clk_i) begin
      if (enq_fire) begin
         mem_r[wptr_r[idx_width_lp-1:0]] <= q_if.enq_data_i;
      end
   end

   assign q_if.enq_ready_o = enq_ready;
   assign q_if.deq_v_o     = deq_v;
   assign q_if.deq_data_o  = deq_data;
   assign q_if.count_o     = count;

`ifndef SYNTHESIS
   // The scheduler may only take an entry that is being offered.
   a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      q_if.deq_yumi_i |-> deq_v);

   // Only issued entries can be committed.
   a_cmt_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      q_if.cmt_i |-> (cptr_r != rptr_r));

   // Occupancy can never exceed the array depth.
   a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      count <= ptr_t'(els_p));
`endif

endmodule

// File: tb/tb_bp_be_issue_queue_roll.sv
// Self-checking bench for bp_be_issue_queue_roll (els_p=4, entry_width_p=8).
// The reference model keeps every uncommitted packet in a queue plus a count
// of how many of those have been issued; expected deq data is looked up from
// it when stimulus is driven and compared against what the DUT offers.
// Build with BP_BE_ISSUE_QUEUE_BYPASS_EN to also cover the bypass path.
module tb_bp_be_issue_queue_roll;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   bp_be_issue_queue_roll_if #(.entry_width_p(8), .els_p(4)) q_if ();

   bp_be_issue_queue_roll #(.entry_width_p(8), .els_p(4)) dut
     (.clk_i     (clk)
     ,.reset_n_i (rst_n)
     ,.q_if      (q_if)
     );

   int total = 0;
   int bad   = 0;

   // Reference model: uncommitted packets, oldest first, and issued count.
   logic [7:0] pend [$];
   int         n_iss = 0;

   // Values observed at the falling edge of the last cycle, and the model's
   // expectation for that same cycle.
   logic       o_v, o_rdy;
   logic [7:0] o_d;
   logic       m_v, m_rdy;
   logic [7:0] m_d;

   // Drive one cycle of stimulus, sample outputs mid-cycle, advance the model.
   task automatic cyc(input logic ev, input logic [7:0] ed, input logic y,
                      input logic c, input logic r, input logic cl);
      logic fire, cmt_ok;
      q_if.enq_v_i    = ev;
      q_if.enq_data_i = ed;
      q_if.deq_yumi_i = y;
      q_if.cmt_i      = c;
      q_if.roll_i     = r;
      q_if.clr_i      = cl;
      @(negedge clk);
      o_v   = q_if.deq_v_o;
      o_d   = q_if.deq_data_o;
      o_rdy = q_if.enq_ready_o;
      m_rdy = (pend.size() < 4) && !cl;
      fire  = ev && m_rdy;
      m_v   = n_iss < pend.size();
      m_d   = m_v ? pend[n_iss] : 8'h00;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
      if (!m_v && fire && !r) begin
         m_v = 1'b1;
         m_d = ed;
      end
`endif
      @(posedge clk);
      #1;
      if (cl) begin
         pend.delete();
         n_iss = 0;
      end else if (r) begin
         if (c && n_iss > 0) void'(pend.pop_front());
         n_iss = 0;
         if (fire) pend.push_back(ed);
      end else begin
         cmt_ok = c && (n_iss > 0);
         if (fire) pend.push_back(ed);
         if (y && m_v) n_iss++;
         if (cmt_ok) begin
            void'(pend.pop_front());
            n_iss--;
         end
      end
      q_if.enq_v_i    = 1'b0;
      q_if.enq_data_i = 8'h00;
      q_if.deq_yumi_i = 1'b0;
      q_if.cmt_i      = 1'b0;
      q_if.roll_i     = 1'b0;
      q_if.clr_i      = 1'b0;
   endtask

   // Issue and commit whatever remains so each scenario starts empty.
   task automatic drain();
      for (int i = 0; i < 16 && pend.size() > 0; i++)
         cyc(1'b0, 8'h00, n_iss < pend.size(), n_iss > 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++; if (q_if.count_o !== 3'd0) begin bad++; $display("FAIL rst_count got %0d want 0", q_if.count_o); end
      total++; if (q_if.deq_v_o !== 1'b0) begin bad++; $display("FAIL rst_deq_v got %b want 0", q_if.deq_v_o); end
      total++; if (q_if.enq_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", q_if.enq_ready_o); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (q_if.enq_ready_o !== 1'b1) begin bad++; $display("FAIL rst_release_ready got %b want 1", q_if.enq_ready_o); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         total++; if (o_rdy !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got %b want 1", i, o_rdy); end
      end
      total++; if (q_if.count_o !== 3'd4) begin bad++; $display("FAIL fill_count got %0d want 4", q_if.count_o); end
      total++; if (q_if.enq_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got %b want 0", q_if.enq_ready_o); end
      cyc(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (o_rdy !== m_rdy) begin bad++; $display("FAIL full_drop_ready got %b want %b", o_rdy, m_rdy); end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
         total++; if (o_v !== 1'b1 || o_d !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL fill_order[%0d] got v=%b %h want v=1 %h", i, o_v, o_d, 8'hA0 + 8'(i)); end
      end
      total++; if (q_if.deq_v_o !== 1'b0) begin bad++; $display("FAIL fill_issued_empty got %b want 0", q_if.deq_v_o); end
      drain();
      total++; if (q_if.count_o !== 3'd0) begin bad++; $display("FAIL fill_drain_count got %0d want 0", q_if.count_o); end
   endtask

   task automatic test_full_cmt();
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hB4, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (o_rdy !== 1'b0) begin bad++; $display("FAIL full_cmt_ready got %b want 0", o_rdy); end
      total++; if (q_if.count_o !== 3'd3) begin bad++; $display("FAIL full_cmt_count got %0d want 3", q_if.count_o); end
      total++; if (q_if.enq_ready_o !== 1'b1) begin bad++; $display("FAIL full_cmt_next_ready got %b want 1", q_if.enq_ready_o); end
      drain();
   endtask

   task automatic test_rollback();
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
         total++; if (o_d !== m_d) begin bad++; $display("FAIL roll_issue[%0d] got %h want %h", i, o_d, m_d); end
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (q_if.deq_v_o !== 1'b1 || q_if.deq_data_o !== 8'hA1) begin bad++; $display("FAIL roll_data got v=%b %h want v=1 a1", q_if.deq_v_o, q_if.deq_data_o); end
      total++; if (q_if.count_o !== 3'd3) begin bad++; $display("FAIL roll_count got %0d want 3", q_if.count_o); end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
         total++; if (o_d !== 8'hA1 + 8'(i)) begin bad++; $display("FAIL roll_replay[%0d] got %h want %h", i, o_d, 8'hA1 + 8'(i)); end
      end
      drain();
   endtask

   task automatic test_roll_cmt();
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      total++; if (q_if.deq_data_o !== 8'hC1) begin bad++; $display("FAIL roll_cmt_data got %h want c1", q_if.deq_data_o); end
      total++; if (q_if.count_o !== 3'd3) begin bad++; $display("FAIL roll_cmt_count got %0d want 3", q_if.count_o); end
      drain();
   endtask

   task automatic test_clear();
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (q_if.count_o !== 3'd3) begin bad++; $display("FAIL clr_pre_count got %0d want 3", q_if.count_o); end
      cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (o_rdy !== 1'b0) begin bad++; $display("FAIL clr_ready got %b want 0", o_rdy); end
      total++; if (q_if.count_o !== 3'd0 || q_if.deq_v_o !== 1'b0) begin bad++; $display("FAIL clr_state got cnt=%0d v=%b want cnt=0 v=0", q_if.count_o, q_if.deq_v_o); end
      cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (o_v !== 1'b1 || o_d !== 8'h11) begin bad++; $display("FAIL clr_after got v=%b %h want v=1 11", o_v, o_d); end
      total++; if (q_if.deq_v_o !== 1'b0) begin bad++; $display("FAIL clr_no_ghost got %b want 0", q_if.deq_v_o); end
      drain();
   endtask

   task automatic test_wrap();
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 4; i++) cyc(1'b1, 8'(r * 4 + i), 1'b0, 1'b0, 1'b0, 1'b0);
         total++; if (q_if.count_o > 3'd4 || q_if.count_o !== 3'd4) begin bad++; $display("FAIL wrap_count[%0d] got %0d want 4", r, q_if.count_o); end
         for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            total++; if (o_d !== 8'(r * 4 + i)) begin bad++; $display("FAIL wrap_data[%0d] got %h want %h", r * 4 + i, o_d, 8'(r * 4 + i)); end
         end
         for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      total++; if (q_if.count_o !== 3'd0) begin bad++; $display("FAIL wrap_end_count got %0d want 0", q_if.count_o); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 24; k++) begin
         cyc(1'b1, 8'h60 + 8'(k), n_iss < pend.size(), n_iss > 0, 1'b0, 1'b0);
         total++; if (o_v !== m_v || o_rdy !== m_rdy || (m_v && o_d !== m_d)) begin bad++; $display("FAIL b2b[%0d] got v=%b rdy=%b %h want v=%b rdy=%b %h", k, o_v, o_rdy, o_d, m_v, m_rdy, m_d); end
      end
      drain();
      total++; if (q_if.count_o !== 3'd0) begin bad++; $display("FAIL b2b_end_count got %0d want 0", q_if.count_o); end
   endtask

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
   task automatic test_bypass();
      cyc(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (o_v !== 1'b1 || o_d !== 8'h5C) begin bad++; $display("FAIL bypass got v=%b %h want v=1 5c", o_v, o_d); end
      total++; if (q_if.count_o !== 3'd1 || q_if.deq_v_o !== 1'b0) begin bad++; $display("FAIL bypass_state got cnt=%0d v=%b want cnt=1 v=0", q_if.count_o, q_if.deq_v_o); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (q_if.deq_data_o !== 8'h5C) begin bad++; $display("FAIL bypass_replay got %h want 5c", q_if.deq_data_o); end
      drain();
   endtask
`endif

   task automatic test_reset_midrun();
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'hF0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (q_if.count_o !== 3'd3) begin bad++; $display("FAIL mid_pre_count got %0d want 3", q_if.count_o); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (q_if.deq_v_o !== 1'b0 || q_if.count_o !== 3'd0) begin bad++; $display("FAIL mid_rst got v=%b cnt=%0d want v=0 cnt=0", q_if.deq_v_o, q_if.count_o); end
      pend.delete();
      n_iss = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (q_if.enq_ready_o !== 1'b1) begin bad++; $display("FAIL mid_release_ready got %b want 1", q_if.enq_ready_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      q_if.enq_v_i    = 1'b0;
      q_if.enq_data_i = 8'h00;
      q_if.deq_yumi_i = 1'b0;
      q_if.cmt_i      = 1'b0;
      q_if.roll_i     = 1'b0;
      q_if.clr_i      = 1'b0;
      test_reset();
      test_fill();
      test_full_cmt();
      test_rollback();
      test_roll_cmt();
      test_clear();
      test_wrap();
      test_back_to_back();
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
      test_bypass();
`endif
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
